clock_switch_ctrl_m: RTL and testbench

- Initiator side of the HS/LS clock-switch handshake.
- Decides whether the CPU should run on the high-speed clock or the low-speed (host) clock, based on per-cycle access decode.
- Drives the switch's select line, then waits for the switch's selected-HS/selected-LS status.
- Stalls the CPU via RDY while a required switch is in flight; flags handshakes that never complete.

---
 rtl/clock_switch_ctrl_m.sv | 153 +++++++++++++++
 tb/tb_clock_switch_ctrl_m.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_ctrl_m.sv
// Initiator side of the HS/LS clock-switch handshake: picks the CPU clock from
// the access decode, drives the switch select and stalls the CPU while a switch is in flight.
module clock_switch_ctrl_m #(
  parameter int SYNC_STAGES    = 2,
  parameter int HS_HOLDOFF     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic ck_ip,
  input  logic resetb,
  input  logic access_valid_ip,
  input  logic access_ls_ip,
  input  logic force_ls_ip,
  input  logic selected_hs_ip,
  input  logic selected_ls_ip,
  input  logic err_clr_ip,
  output logic select_hs_op,
  output logic rdy_op,
  output logic hs_mode_op,
  output logic timeout_err_op
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HO_W  = $clog2(HS_HOLDOFF + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HO_W-1:0]  HO_MAX   = HO_W'(HS_HOLDOFF);

  typedef enum logic [1:0] {
    REQ_LS = 2'd0,
    LS_RUN = 2'd1,
    REQ_HS = 2'd2,
    HS_RUN = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_shs_sync;
  logic [SYNC_STAGES-1:0] r_sls_sync;
  logic [TMR_W-1:0]       r_tmr;
  logic [HO_W-1:0]        r_holdoff;
  logic                   r_booted;

  state_t           w_nxt;
  logic             w_shs;
  logic             w_sls;
  logic             w_want_ls;
  logic             w_hs_ok;
  logic             w_set_err;
  logic             w_tmr_run;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [HO_W-1:0]  w_ho_nxt;
  logic             w_booted;
  logic             w_rdy;

  assign w_shs     = r_shs_sync[SYNC_STAGES-1];
  assign w_sls     = r_sls_sync[SYNC_STAGES-1];
  assign w_want_ls = force_ls_ip | (access_valid_ip & access_ls_ip);
  assign w_hs_ok   = access_valid_ip & ~access_ls_ip & ~force_ls_ip;

  // Next-state decode; the timer only advances while a request is pending
  always_comb begin
    w_nxt     = r_state;
    w_set_err = 1'b0;
    w_tmr_run = 1'b0;
    case (r_state)
      REQ_LS: begin
        if (w_sls) begin
          w_nxt = LS_RUN;
        end else if (r_tmr == TMR_LAST) begin
          w_set_err = 1'b1;
        end else begin
          w_tmr_run = 1'b1;
        end
      end
      LS_RUN: begin
        if (!w_sls) begin
          w_nxt     = REQ_LS;
          w_set_err = 1'b1;
        end else if (!w_want_ls && (r_holdoff == HO_MAX)) begin
          w_nxt = REQ_HS;
        end
      end
      REQ_HS: begin
        if (w_want_ls) begin
          w_nxt = REQ_LS;
        end else if (w_shs) begin
          w_nxt = HS_RUN;
        end else if (r_tmr == TMR_LAST) begin
          w_nxt     = REQ_LS;
          w_set_err = 1'b1;
        end else begin
          w_tmr_run = 1'b1;
        end
      end
      HS_RUN: begin
        if (w_want_ls) begin
          w_nxt = REQ_LS;
        end else if (!w_shs) begin
          w_nxt     = REQ_LS;
          w_set_err = 1'b1;
        end
      end
      default: w_nxt = REQ_LS;
    endcase
  end

  // Holdoff only accumulates while staying in LS_RUN; an LS demand resets the run
  always_comb begin
    w_ho_nxt = '0;
    if ((r_state == LS_RUN) && (w_nxt == LS_RUN)) begin
      if (w_want_ls) begin
        w_ho_nxt = '0;
      end else if (w_hs_ok && (r_holdoff != HO_MAX)) begin
        w_ho_nxt = r_holdoff + HO_W'(1);
      end else begin
        w_ho_nxt = r_holdoff;
      end
    end
  end

  assign w_tmr_nxt = w_tmr_run ? (r_tmr + TMR_W'(1)) : '0;

  // The CPU is held until the first LS handshake after reset has completed
  assign w_booted = r_booted | (w_nxt == LS_RUN);
  assign w_rdy    = w_booted
                  & ~(((w_nxt == REQ_LS) || (w_nxt == REQ_HS)) & access_valid_ip)
                  & ~((w_nxt == REQ_LS) & force_ls_ip);

  always_ff @(posedge ck_ip or negedge resetb) begin
    if (!resetb) begin
      r_state        <= REQ_LS;
      r_shs_sync     <= '0;
      r_sls_sync     <= '0;
      r_tmr          <= '0;
      r_holdoff      <= '0;
      r_booted       <= 1'b0;
      select_hs_op   <= 1'b0;
      rdy_op         <= 1'b0;
      hs_mode_op     <= 1'b0;
      timeout_err_op <= 1'b0;
    end else begin
      r_shs_sync     <= {r_shs_sync[SYNC_STAGES-2:0], selected_hs_ip};
      r_sls_sync     <= {r_sls_sync[SYNC_STAGES-2:0], selected_ls_ip};
      r_state        <= w_nxt;
      r_tmr          <= w_tmr_nxt;
      r_holdoff      <= w_ho_nxt;
      r_booted       <= w_booted;
      select_hs_op   <= (w_nxt == REQ_HS) || (w_nxt == HS_RUN);
      hs_mode_op     <= (w_nxt == HS_RUN);
      rdy_op         <= w_rdy;
      timeout_err_op <= w_set_err ? 1'b1 : (err_clr_ip ? 1'b0 : timeout_err_op);
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl_m.sv
// Directed bench for clock_switch_ctrl_m: boot handshake, upswitch, downswitch,
// holdoff reset, abort priority, REQ_HS / REQ_LS timeouts and error flag clearing.
module tb_clock_switch_ctrl_m;

  logic ck = 1'b0;
  logic resetb = 1'b1;
  logic av = 1'b0;
  logic als = 1'b0;
  logic force_ls = 1'b0;
  logic shs = 1'b0;
  logic sls = 1'b0;
  logic err_clr = 1'b0;
  logic sel_hs;
  logic rdy;
  logic hs_mode;
  logic terr;

  int n_vec = 0;
  int n_err = 0;

  clock_switch_ctrl_m #(
    .SYNC_STAGES(2),
    .HS_HOLDOFF(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .ck_ip(ck),
    .resetb(resetb),
    .access_valid_ip(av),
    .access_ls_ip(als),
    .force_ls_ip(force_ls),
    .selected_hs_ip(shs),
    .selected_ls_ip(sls),
    .err_clr_ip(err_clr),
    .select_hs_op(sel_hs),
    .rdy_op(rdy),
    .hs_mode_op(hs_mode),
    .timeout_err_op(terr)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #1 resetb = 1'b0;
    #2;
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_sel", sel_hs, 1'b0);
    chk("rst_hs", hs_mode, 1'b0);
    chk("rst_err", terr, 1'b0);
    ticks(2);
    resetb = 1'b1;

    // Boot: no LS status yet, CPU must stay stalled
    ticks(2);
    chk("boot_wait_rdy", rdy, 1'b0);
    sls = 1'b1;
    ticks(2);
    chk("boot_sync_rdy", rdy, 1'b0);
    tick();
    chk("boot_rdy", rdy, 1'b1);
    chk("boot_sel", sel_hs, 1'b0);
    chk("boot_hs", hs_mode, 1'b0);

    // Upswitch after four HS-eligible accesses
    av = 1'b1; als = 1'b0;
    ticks(3);
    chk("up_hold3_sel", sel_hs, 1'b0);
    tick();
    chk("up_hold4_sel", sel_hs, 1'b0);
    chk("up_hold4_rdy", rdy, 1'b1);
    av = 1'b0;
    tick();
    chk("up_req_sel", sel_hs, 1'b1);
    chk("up_req_rdy", rdy, 1'b1);
    chk("up_req_hs", hs_mode, 1'b0);
    ticks(3);
    shs = 1'b1; sls = 1'b0;
    ticks(2);
    chk("up_sync_hs", hs_mode, 1'b0);
    tick();
    chk("up_run_hs", hs_mode, 1'b1);
    chk("up_run_sel", sel_hs, 1'b1);

    // Downswitch on an LS access, stalled until the LS status returns
    av = 1'b1; als = 1'b1;
    tick();
    chk("dn_sel", sel_hs, 1'b0);
    chk("dn_hs", hs_mode, 1'b0);
    chk("dn_rdy0", rdy, 1'b0);
    shs = 1'b0; sls = 1'b1;
    ticks(2);
    chk("dn_wait_rdy", rdy, 1'b0);
    tick();
    chk("dn_done_rdy", rdy, 1'b1);
    chk("dn_err", terr, 1'b0);

    // Interrupted holdoff: 3 HS, 1 LS, 3 HS, idle
    av = 1'b1; als = 1'b0;
    ticks(3);
    als = 1'b1;
    tick();
    chk("ho_ls_rdy", rdy, 1'b1);
    als = 1'b0;
    ticks(3);
    chk("ho_3hs_sel", sel_hs, 1'b0);
    av = 1'b0;
    ticks(2);
    chk("ho_idle_sel", sel_hs, 1'b0);

    // Fourth HS access completes the run; then abort while sHS rises
    av = 1'b1;
    tick();
    av = 1'b0;
    tick();
    chk("ab_req_sel", sel_hs, 1'b1);
    shs = 1'b1; sls = 1'b0;
    ticks(2);
    chk("ab_sync_hs", hs_mode, 1'b0);
    force_ls = 1'b1;
    tick();
    chk("ab_sel", sel_hs, 1'b0);
    chk("ab_hs", hs_mode, 1'b0);
    chk("ab_rdy", rdy, 1'b0);
    shs = 1'b0; sls = 1'b1;
    tick();
    chk("ab_ls1_hs", hs_mode, 1'b0);
    tick();
    chk("ab_ls2_rdy", rdy, 1'b0);
    tick();
    chk("ab_done_rdy", rdy, 1'b1);
    chk("ab_done_hs", hs_mode, 1'b0);
    chk("ab_err", terr, 1'b0);
    force_ls = 1'b0;

    // REQ_HS timeout: switch never acknowledges HS
    av = 1'b1; als = 1'b0;
    ticks(4);
    av = 1'b0;
    tick();
    chk("to_req_sel", sel_hs, 1'b1);
    ticks(63);
    chk("to_63_sel", sel_hs, 1'b1);
    chk("to_63_err", terr, 1'b0);
    tick();
    chk("to_64_sel", sel_hs, 1'b0);
    chk("to_64_err", terr, 1'b1);
    chk("to_64_hs", hs_mode, 1'b0);
    tick();
    chk("to_sticky_err", terr, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr_err", terr, 1'b0);

    // LS status drops in LS_RUN together with a clear: set wins
    sls = 1'b0;
    ticks(2);
    chk("lsdrop_pre_err", terr, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("lsdrop_err", terr, 1'b1);
    chk("lsdrop_sel", sel_hs, 1'b0);

    // REQ_LS timeout with no LS status
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("rqls_clr_err", terr, 1'b0);
    ticks(62);
    chk("rqls_62_err", terr, 1'b0);
    tick();
    chk("rqls_63_err", terr, 1'b1);
    chk("rqls_sel", sel_hs, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
